uart_tx_arbiter: RTL

//  Shares one uart_tx_top transmitter among NUM_REQ byte requesters. Round-robin

---
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesting clients, the shared uart_tx_top and the arbiter.
// slave = arbiter side, master = clients plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_parity_en;
  logic [NUM_REQ-1:0]        req_parity_type;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_data_valid;
  logic                      tx_parity_en;
  logic                      tx_parity_type;
  logic                      tx_done;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;
  logic                      timeout_err;

  modport slave (
    input  req_valid, req_data, req_parity_en, req_parity_type, tx_done,
    output req_ready, tx_data, tx_data_valid, tx_parity_en, tx_parity_type,
           busy, grant_id, timeout_err
  );

  modport master (
    output req_valid, req_data, req_parity_en, req_parity_type, tx_done,
    input  req_ready, tx_data, tx_data_valid, tx_parity_en, tx_parity_type,
           busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx_top among NUM_REQ byte requesters.
// Define UART_TX_ARB_TIMEOUT_EN to enable the WAIT_DONE timeout (TIMEOUT cycles).
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk1,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_DONE} state_t;

  state_t               r_state;
  logic [ID_W-1:0]      r_last;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [DATA_W-1:0]    r_tx_data;
  logic                 r_tx_data_valid;
  logic                 r_tx_parity_en;
  logic                 r_tx_parity_type;
  logic                 r_busy;
  logic [ID_W-1:0]      r_grant_id;

  logic [DATA_W-1:0]    w_req_bytes [NUM_REQ];
  logic                 w_found;
  logic [ID_W-1:0]      w_winner;
  logic [ID_W-1:0]      w_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_req_bytes[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  // Search order starts just after the last completed grant, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = ID_W'((int'(r_last) + i) % NUM_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;
  assign bus.timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign bus.timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      r_state          <= S_IDLE;
      r_last           <= ID_W'(NUM_REQ - 1);
      r_req_ready      <= '0;
      r_tx_data        <= '0;
      r_tx_data_valid  <= 1'b0;
      r_tx_parity_en   <= 1'b0;
      r_tx_parity_type <= 1'b0;
      r_busy           <= 1'b0;
      r_grant_id       <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_cnt            <= '0;
      r_timeout_err    <= 1'b0;
`endif
    end else begin
      r_req_ready     <= '0;
      r_tx_data_valid <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_timeout_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_tx_data        <= w_req_bytes[w_winner];
            r_tx_parity_en   <= bus.req_parity_en[w_winner];
            r_tx_parity_type <= bus.req_parity_type[w_winner];
            r_req_ready      <= NUM_REQ'(1) << w_winner;
            r_tx_data_valid  <= 1'b1;
            r_busy           <= 1'b1;
            r_grant_id       <= w_winner;
            r_state          <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        S_WAIT_DONE: begin
          // tx_done on the final timeout cycle takes precedence over the error.
          if (bus.tx_done) begin
            r_busy  <= 1'b0;
            r_last  <= r_grant_id;
            r_state <= S_IDLE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_busy        <= 1'b0;
            r_last        <= r_grant_id;
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.tx_data        = r_tx_data;
  assign bus.tx_data_valid  = r_tx_data_valid;
  assign bus.tx_parity_en   = r_tx_parity_en;
  assign bus.tx_parity_type = r_tx_parity_type;
  assign bus.busy           = r_busy;
  assign bus.grant_id       = r_grant_id;
endmodule
